dcache_miss_ctrl: RTL and testbench
===================================

Name: dcache_miss_ctrl

Overview:
- Sits directly downstream of the direct-mapped data cache (8 sets, 27-bit tag, one 32-bit word per line) and upstream of data memory.
- Services load misses: fetches the word from memory and returns a refill (set, tag, data) for the cache to install.
- Stores are write-through; they are absorbed by a small FIFO write buffer that drains to memory in the background.
- Drives the pipeline stall while a miss is outstanding or the write buffer is full.

Parameters:
- DATA_WIDTH, 32, data word width.
- ADDRESS_WIDTH, 32, byte address width.
- SET_BITS, 3, cache index bits (addr[SET_BITS+1:2]).
- WB_DEPTH, 4, write-buffer entries; power of two, ≥2.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset
- miss_valid  in  1  cache reports load miss this cycle
- miss_addr  in  ADDRESS_WIDTH  byte address of missing load
- st_valid  in  1  store issued this cycle
- st_addr  in  ADDRESS_WIDTH  store byte address
- st_data  in  DATA_WIDTH  store data, byte-lane aligned
- st_be  in  DATA_WIDTH/8  store byte enables
- stall  out  1  freeze pipeline
- refill_valid  out  1  one-cycle install pulse to cache
- refill_set  out  SET_BITS  set to install
- refill_tag  out  ADDRESS_WIDTH-SET_BITS-2  tag to install
- refill_data  out  DATA_WIDTH  word to install and forward to load
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDRESS_WIDTH  word-aligned address, [1:0]=0
- mem_wdata  out  DATA_WIDTH  write data
- mem_be  out  DATA_WIDTH/8  write byte enables
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_WIDTH  read data

Behaviour:
- Reset: rst is synchronous and active-high. On reset: FSM→IDLE, buffer emptied, and stall, refill_valid, mem_req, mem_we, mem_be all 0. All data outputs are 0.
- Reset mid-miss: the request is abandoned. A late mem_rvalid is ignored; mem_rvalid is ignored in every state except RD_WAIT.
- FSM states: IDLE, DRAIN, RD_REQ, RD_WAIT, REFILL.
- IDLE:
  - miss_valid=1: capture miss_addr. Go to DRAIN if the buffer is non-empty, else RD_REQ.
  - Otherwise, a non-empty buffer presents its head as a write.
- DRAIN: present the head as a write; go to RD_REQ once the buffer is empty.
- Write port: mem_req=1, mem_we=1, mem_addr={head.addr[31:2],2'b00}, mem_wdata/mem_be = head. The head pops in the cycle where mem_ready=1.
- RD_REQ:
  - mem_req=1, mem_we=0, mem_addr=captured word address.
  - On mem_ready → RD_WAIT.
- RD_WAIT: on mem_rvalid, capture mem_rdata → REFILL. There is no timeout.
- REFILL:
  - refill_valid=1 for exactly one cycle.
  - set/tag are sliced from the captured address; refill_data = captured word.
  - stall=0 in this cycle. Next state IDLE.
- stall = (state∉{IDLE,REFILL}) | (state==IDLE & miss_valid) | (st_valid & wb_full).
- miss_valid is sampled only in IDLE; it is ignored in other states because the pipeline is frozen.
- Store enqueue:
  - Happens in any state when st_valid=1 and the buffer is not full.
  - Full is evaluated before any same-cycle pop, so there is no enqueue when full even if a pop occurs.
  - A store hit stalled by full is re-presented by the frozen pipeline.
- Same-cycle st_valid and miss_valid in IDLE: the store is enqueued first, and the miss waits for it to drain.
- Pointers: wrap modulo WB_DEPTH. A count register of width log2(WB_DEPTH)+1 gives full/empty.
- Latency: with an empty buffer, mem_ready=1, and rvalid one cycle after accept, refill_valid is asserted 3 cycles after the miss_valid cycle.

Optional Feature:
- Macro: DCACHE_WB_BYPASS_EN.
- Defined: a miss skips DRAIN if no buffered entry matches its word address (addr[31:2]). On a match it drains fully as normal. In IDLE with a miss pending, the read has priority over drains.
- Undefined: every miss drains the whole buffer before reading.

Decomposition:
- Shared package dcache_pkg holds:
  - typedef ctrl_state_t (the 5 states);
  - constants TAG_BITS = ADDRESS_WIDTH-SET_BITS-2 and BE_BITS = DATA_WIDTH/8;
  - packed struct wb_entry_t {addr, data, be}.
- One sub-module, dcache_wbuf: the synchronous FIFO with push/pop/full/empty, head output, and an address-match compare vector for the bypass feature.

Test Plan:
- Isolated miss, addr 0x0000_0024, memory returns 0xDEADBEEF one cycle after accept:
  - refill_valid 3 cycles later with set=1, tag=0x0000001, data=0xDEADBEEF;
  - stall high for cycles 0–2 only.
- Four back-to-back stores with mem_ready=0:
  - buffer full; the 5th st_valid raises stall;
  - once mem_ready=1, the stores drain in order with correct be/wdata.
- Store to 0x100 (data 0x11223344, be 0xF), then miss to 0x100:
  - the write is issued before the read in both builds;
  - with DCACHE_WB_BYPASS_EN and a miss to 0x200, the read is issued first.
- Same-cycle st_valid and miss_valid in IDLE: the store is enqueued, DRAIN is entered, and the write precedes the read.
- rst asserted in RD_WAIT, then mem_rvalid=1 the next cycle: no refill_valid, and all outputs hold their reset values.
- mem_ready held low for 5 cycles in RD_REQ: mem_req and mem_addr stay stable, and stall stays high throughout.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and constants for the data-cache miss controller and its write buffer.
package dcache_pkg;

    localparam int PKG_DATA_WIDTH    = 32;
    localparam int PKG_ADDRESS_WIDTH = 32;
    localparam int PKG_SET_BITS      = 3;

    localparam int TAG_BITS = PKG_ADDRESS_WIDTH - PKG_SET_BITS - 2;
    localparam int BE_BITS  = PKG_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        RD_REQ,
        RD_WAIT,
        REFILL
    } ctrl_state_t;

    typedef struct packed {
        logic [PKG_ADDRESS_WIDTH-1:0] addr;
        logic [PKG_DATA_WIDTH-1:0]    data;
        logic [BE_BITS-1:0]           be;
    } wb_entry_t;

endpackage

// File: rtl/dcache_wbuf.sv
// Write-through store FIFO: push/pop with count-based full/empty, head output and a
// per-slot word-address match vector used when DCACHE_WB_BYPASS_EN is defined.
module dcache_wbuf
    import dcache_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  wb_entry_t                      push_entry,
    input  logic                           pop,
    input  logic [PKG_ADDRESS_WIDTH-3:0]   match_addr,
    output wb_entry_t                      head,
    output logic                           full,
    output logic                           empty,
    output logic [DEPTH-1:0]               match_vec
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    wb_entry_t        mem_reg [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign full    = (count_reg == FULL_COUNT);
    assign empty   = (count_reg == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop_ok};
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_reg[wr_ptr_reg] <= push_entry;
    end

    // A slot holds live data when its distance from the read pointer is below the count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            logic [PTR_W-1:0] offs;
            logic             slot_live;
            assign offs         = PTR_W'(gi) - rd_ptr_reg;
            assign slot_live    = ({1'b0, offs} < count_reg);
            assign match_vec[gi] = slot_live &&
                (mem_reg[gi].addr[PKG_ADDRESS_WIDTH-1:2] == match_addr);
        end
    endgenerate

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Load-miss refill engine with write-through store buffer for the direct-mapped D-cache.
// Optional macro DCACHE_WB_BYPASS_EN lets a miss read ahead of non-matching buffered stores.
module dcache_miss_ctrl
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH    = PKG_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = PKG_ADDRESS_WIDTH,
    parameter int SET_BITS      = PKG_SET_BITS,
    parameter int WB_DEPTH      = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                miss_valid,
    input  logic [ADDRESS_WIDTH-1:0]            miss_addr,
    input  logic                                st_valid,
    input  logic [ADDRESS_WIDTH-1:0]            st_addr,
    input  logic [DATA_WIDTH-1:0]               st_data,
    input  logic [DATA_WIDTH/8-1:0]             st_be,
    output logic                                stall,
    output logic                                refill_valid,
    output logic [SET_BITS-1:0]                 refill_set,
    output logic [ADDRESS_WIDTH-SET_BITS-3:0]   refill_tag,
    output logic [DATA_WIDTH-1:0]               refill_data,
    output logic                                mem_req,
    output logic                                mem_we,
    output logic [ADDRESS_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]               mem_wdata,
    output logic [DATA_WIDTH/8-1:0]             mem_be,
    input  logic                                mem_ready,
    input  logic                                mem_rvalid,
    input  logic [DATA_WIDTH-1:0]               mem_rdata
);

    ctrl_state_t state_reg, state_next;
    logic [ADDRESS_WIDTH-3:0] miss_word_reg, miss_word_next;
    logic [DATA_WIDTH-1:0]    rdata_reg, rdata_next;

    wb_entry_t         wb_head;
    wb_entry_t         wb_push_entry;
    logic              wb_full;
    logic              wb_empty;
    logic              wb_pop;
    logic              st_push;
    logic [WB_DEPTH-1:0] wb_match;
    logic              miss_needs_drain;
    logic              do_write;
    logic              addr_lsb_unused;

    assign st_push       = st_valid & ~wb_full;
    assign wb_push_entry = '{addr: st_addr, data: st_data, be: st_be};
    assign addr_lsb_unused = ^{miss_addr[1:0], wb_head.addr[1:0]};

    dcache_wbuf #(
        .DEPTH(WB_DEPTH)
    ) u_wbuf (
        .clk        (clk),
        .rst        (rst),
        .push       (st_push),
        .push_entry (wb_push_entry),
        .pop        (wb_pop),
        .match_addr (miss_addr[ADDRESS_WIDTH-1:2]),
        .head       (wb_head),
        .full       (wb_full),
        .empty      (wb_empty),
        .match_vec  (wb_match)
    );

    // A store arriving alongside the miss counts as buffered: it must reach memory first.
`ifdef DCACHE_WB_BYPASS_EN
    assign miss_needs_drain = (|wb_match) ||
        (st_push && (st_addr[ADDRESS_WIDTH-1:2] == miss_addr[ADDRESS_WIDTH-1:2]));
`else
    logic wb_match_unused;
    assign wb_match_unused  = |wb_match;
    assign miss_needs_drain = ~wb_empty | st_push;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            miss_word_reg <= '0;
            rdata_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            miss_word_reg <= miss_word_next;
            rdata_reg     <= rdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        miss_word_next = miss_word_reg;
        rdata_next     = rdata_reg;
        do_write       = 1'b0;
        wb_pop         = 1'b0;
        refill_valid   = 1'b0;
        refill_set     = '0;
        refill_tag     = '0;
        refill_data    = '0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_be         = '0;

        case (state_reg)
            IDLE: begin
                if (miss_valid) begin
                    miss_word_next = miss_addr[ADDRESS_WIDTH-1:2];
                    state_next     = miss_needs_drain ? DRAIN : RD_REQ;
                end else begin
                    do_write = ~wb_empty;
                end
            end
            DRAIN: begin
                if (wb_empty) state_next = RD_REQ;
                else          do_write   = 1'b1;
            end
            RD_REQ: begin
                mem_req  = 1'b1;
                mem_addr = {miss_word_reg, 2'b00};
                if (mem_ready) state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rvalid) begin
                    rdata_next = mem_rdata;
                    state_next = REFILL;
                end
            end
            REFILL: begin
                refill_valid = 1'b1;
                refill_set   = miss_word_reg[SET_BITS-1:0];
                refill_tag   = miss_word_reg[ADDRESS_WIDTH-3:SET_BITS];
                refill_data  = rdata_reg;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (do_write) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {wb_head.addr[ADDRESS_WIDTH-1:2], 2'b00};
            mem_wdata = wb_head.data;
            mem_be    = wb_head.be;
            wb_pop    = mem_ready;
        end
    end

    assign stall = ((state_reg != IDLE) && (state_reg != REFILL)) ||
                   ((state_reg == IDLE) && miss_valid) ||
                   (st_valid && wb_full);

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl: scoreboarded memory transactions and refills,
// plus cycle-exact stall/output checks at each step.
module tb_dcache_miss_ctrl;

    logic        clk;
    logic        rst;
    logic        miss_valid;
    logic [31:0] miss_addr;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic        stall;
    logic        refill_valid;
    logic [2:0]  refill_set;
    logic [26:0] refill_tag;
    logic [31:0] refill_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_cmp;
    int n_fail;
    logic auto_rsp;
    logic [127:0] exp_mem[$];
    logic [127:0] exp_refill[$];
    logic [3:0] be_tab [4];

    dcache_miss_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .miss_valid   (miss_valid),
        .miss_addr    (miss_addr),
        .st_valid     (st_valid),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_be        (st_be),
        .stall        (stall),
        .refill_valid (refill_valid),
        .refill_set   (refill_set),
        .refill_tag   (refill_tag),
        .refill_data  (refill_data),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ready    (mem_ready),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (a == 32'h24) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [127:0] mem_txn(input logic we, input logic [31:0] a,
                                             input logic [31:0] d, input logic [3:0] be);
        return {59'd0, we, a, d, be};
    endfunction

    function automatic logic [127:0] refill_txn(input logic [2:0] s, input logic [26:0] t,
                                                input logic [31:0] d);
        return {66'd0, s, t, d};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // Memory read responder: data returns the cycle after the request is accepted.
    initial begin
        logic acc;
        logic [31:0] acc_addr;
        forever begin
            @(negedge clk);
            acc      = auto_rsp && mem_req && !mem_we && mem_ready;
            acc_addr = mem_addr;
            @(posedge clk);
            #1;
            if (auto_rsp) begin
                mem_rvalid = acc;
                mem_rdata  = acc ? rd_word(acc_addr) : 32'd0;
            end
        end
    end

    // Scoreboard: every accepted memory request and every refill pops an expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_req && mem_ready) begin
                    if (exp_mem.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $error("FAIL mem_unexpected: observed addr %0h we %0b expected none",
                               mem_addr, mem_we);
                    end else begin
                        check("mem_txn", mem_txn(mem_we, mem_addr, mem_wdata, mem_be),
                              exp_mem.pop_front());
                    end
                end
                if (refill_valid) begin
                    if (exp_refill.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $error("FAIL refill_unexpected: observed data %0h expected none",
                               refill_data);
                    end else begin
                        check("refill", refill_txn(refill_set, refill_tag, refill_data),
                              exp_refill.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_fail = 0;
        be_tab = '{4'h1, 4'h3, 4'hF, 4'hC};
        rst = 1'b1;
        miss_valid = 1'b0;
        miss_addr = '0;
        st_valid = 1'b0;
        st_addr = '0;
        st_data = '0;
        st_be = '0;
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        auto_rsp = 1'b0;

        // Reset state
        cyc; cyc;
        #1;
        check("rst_stall", stall, 0);
        check("rst_refill_valid", refill_valid, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_refill_data", refill_data, 0);
        rst = 1'b0;
        cyc;

        // Isolated miss, 3-cycle refill latency
        mem_ready = 1'b1;
        auto_rsp = 1'b1;
        exp_mem.push_back(mem_txn(1'b0, 32'h24, 32'd0, 4'h0));
        exp_refill.push_back(refill_txn(3'd1, 27'h1, 32'hDEADBEEF));
        miss_valid = 1'b1;
        miss_addr = 32'h24;
        #1 check("t1_stall_c0", stall, 1);
        cyc;
        miss_valid = 1'b0;
        miss_addr = '0;
        #1 check("t1_stall_c1", stall, 1);
        cyc;
        #1 check("t1_stall_c2", stall, 1);
        check("t1_refill_c2", refill_valid, 0);
        cyc;
        #1 check("t1_stall_c3", stall, 0);
        check("t1_refill_c3", refill_valid, 1);
        cyc;
        #1 check("t1_refill_c4", refill_valid, 0);
        check("t1_stall_c4", stall, 0);

        // Fill the buffer with memory blocked, then drain in order
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1;
            st_addr = 32'h40 + 32'(4 * i) + 32'(i);
            st_data = 32'hA000_0000 + 32'(i) * 32'h0101_0101;
            st_be = be_tab[i];
            exp_mem.push_back(mem_txn(1'b1, 32'h40 + 32'(4 * i), st_data, st_be));
            #1 check("t2_stall_store", stall, 0);
            cyc;
        end
        st_addr = 32'h50;
        st_data = 32'h5555_5555;
        #1 check("t2_stall_full", stall, 1);
        check("t2_head_presented", {mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 32'h40});
        cyc;
        st_valid = 1'b0;
        mem_ready = 1'b1;
        repeat (6) cyc;
        #1 check("t2_drained_req", mem_req, 0);
        check("t2_q_empty", 128'(exp_mem.size()), 128'd0);

        // Store then miss to the same word: write precedes read
        mem_ready = 1'b0;
        st_valid = 1'b1;
        st_addr = 32'h100;
        st_data = 32'h11223344;
        st_be = 4'hF;
        exp_mem.push_back(mem_txn(1'b1, 32'h100, 32'h11223344, 4'hF));
        cyc;
        st_valid = 1'b0;
        miss_valid = 1'b1;
        miss_addr = 32'h100;
        exp_mem.push_back(mem_txn(1'b0, 32'h100, 32'd0, 4'h0));
        exp_refill.push_back(refill_txn(3'd0, 27'h8, rd_word(32'h100)));
        cyc;
        miss_valid = 1'b0;
        mem_ready = 1'b1;
        repeat (8) cyc;
        check("t3_mem_q_empty", 128'(exp_mem.size()), 128'd0);
        check("t3_refill_q_empty", 128'(exp_refill.size()), 128'd0);

        // Store to 0x100 then miss to an unrelated word
        mem_ready = 1'b0;
        st_valid = 1'b1;
        st_addr = 32'h100;
        st_data = 32'h0BAD_CAFE;
        st_be = 4'h5;
        cyc;
        st_valid = 1'b0;
        miss_valid = 1'b1;
        miss_addr = 32'h200;
`ifdef DCACHE_WB_BYPASS_EN
        exp_mem.push_back(mem_txn(1'b0, 32'h200, 32'd0, 4'h0));
        exp_mem.push_back(mem_txn(1'b1, 32'h100, 32'h0BAD_CAFE, 4'h5));
`else
        exp_mem.push_back(mem_txn(1'b1, 32'h100, 32'h0BAD_CAFE, 4'h5));
        exp_mem.push_back(mem_txn(1'b0, 32'h200, 32'd0, 4'h0));
`endif
        exp_refill.push_back(refill_txn(3'd0, 27'h10, rd_word(32'h200)));
        cyc;
        miss_valid = 1'b0;
        mem_ready = 1'b1;
        repeat (8) cyc;
        check("t3b_mem_q_empty", 128'(exp_mem.size()), 128'd0);
        check("t3b_refill_q_empty", 128'(exp_refill.size()), 128'd0);

        // Same-cycle store and miss in IDLE
        st_valid = 1'b1;
        st_addr = 32'h300;
        st_data = 32'hCAFEF00D;
        st_be = 4'h6;
        miss_valid = 1'b1;
        miss_addr = 32'h300;
        exp_mem.push_back(mem_txn(1'b1, 32'h300, 32'hCAFEF00D, 4'h6));
        exp_mem.push_back(mem_txn(1'b0, 32'h300, 32'd0, 4'h0));
        exp_refill.push_back(refill_txn(3'd0, 27'h18, rd_word(32'h300)));
        #1 check("t4_stall", stall, 1);
        cyc;
        st_valid = 1'b0;
        miss_valid = 1'b0;
        #1 check("t4_drain_write", {mem_req, mem_we}, 2'b11);
        repeat (7) cyc;
        check("t4_mem_q_empty", 128'(exp_mem.size()), 128'd0);
        check("t4_refill_q_empty", 128'(exp_refill.size()), 128'd0);

        // Reset while waiting for read data; the late rvalid must be ignored
        auto_rsp = 1'b0;
        mem_rvalid = 1'b0;
        miss_valid = 1'b1;
        miss_addr = 32'h400;
        exp_mem.push_back(mem_txn(1'b0, 32'h400, 32'd0, 4'h0));
        cyc;
        miss_valid = 1'b0;
        cyc;
        #1 check("t5_stall_rdwait", stall, 1);
        rst = 1'b1;
        cyc;
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h12345678;
        #1 check("t5_refill_after_rst", refill_valid, 0);
        check("t5_outputs_after_rst", {stall, mem_req, mem_we, mem_be, mem_addr, refill_data},
              72'd0);
        cyc;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        #1 check("t5_refill_late", refill_valid, 0);
        check("t5_stall_late", stall, 0);
        check("t5_mem_q_empty", 128'(exp_mem.size()), 128'd0);
        auto_rsp = 1'b1;

        // Memory not ready for 5 cycles in RD_REQ
        mem_ready = 1'b0;
        miss_valid = 1'b1;
        miss_addr = 32'h5C;
        cyc;
        miss_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 check("t6_hold", {stall, mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 1'b0, 32'h5C});
            cyc;
        end
        exp_mem.push_back(mem_txn(1'b0, 32'h5C, 32'd0, 4'h0));
        exp_refill.push_back(refill_txn(3'd7, 27'h2, rd_word(32'h5C)));
        mem_ready = 1'b1;
        repeat (5) cyc;
        check("t6_mem_q_empty", 128'(exp_mem.size()), 128'd0);
        check("t6_refill_q_empty", 128'(exp_refill.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
